// File: rtl/npu_bram_arbiter.sv
// Round-robin arbiter that shares one npu_bram_ctrl port among NUM_REQ requesters.
// The controller is held in reset except while a granted operation is being issued.
module npu_bram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int RD_BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*32-1:0]      req_addr,
    input  logic [NUM_REQ*RD_BITS-1:0] req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [RD_BITS-1:0]         rsp_data,
    output logic                       ctrl_rst,
    output logic                       ctrl_rden,
    output logic [31:0]                ctrl_offset,
    output logic [RD_BITS-1:0]         ctrl_din,
    input  logic [RD_BITS-1:0]         ctrl_dout,
    output logic                       busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a requester holds req_valid (with we/addr/wdata stable) until it
    // sees its one-cycle req_ready pulse; that cycle is the accept. Read data is
    // returned later with a one-cycle rsp_valid pulse on the same index.
    typedef enum logic [2:0] {IDLE, ISSUE, WR_COMMIT, RD_WAIT, RD_RESP} state_t;
    state_t state, state_nxt;

    logic [IW-1:0]      rr_ptr, win, idx, sel_q;
    logic               found, sel_we, we_q;
    logic [31:0]        sel_addr, addr_q;
    logic [RD_BITS-1:0] sel_wdata, wdata_q;

    // Search starts at rr_ptr so the most recent winner has lowest priority.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        idx       = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IW'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[32*i +: 32];
                sel_wdata = req_wdata[RD_BITS*i +: RD_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (found) state_nxt = ISSUE;
            ISSUE:     state_nxt = we_q ? WR_COMMIT : RD_WAIT;
            WR_COMMIT: state_nxt = IDLE;
            RD_WAIT:   state_nxt = RD_RESP;
            RD_RESP:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && found) begin
            rr_ptr  <= IW'((int'(win) + 1) % NUM_REQ);
            sel_q   <= win;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    // Offset and write data come straight from the latched request, so ctrl_* never sees req_* combinationally.
    assign ctrl_offset = addr_q;
    assign ctrl_din    = wdata_q;

    always_comb begin
        ctrl_rst  = 1'b1;
        ctrl_rden = 1'b0;
        busy      = (state != IDLE);
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        case (state)
            IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = found && (win == IW'(i));
                end
            end
            ISSUE: begin
                ctrl_rst  = 1'b0;
                ctrl_rden = ~we_q;
            end
            RD_WAIT: begin
                ctrl_rst  = 1'b0;
                ctrl_rden = 1'b1;
            end
            RD_RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    rsp_valid[i] = (sel_q == IW'(i));
                end
                rsp_data = ctrl_dout;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_npu_bram_arbiter.sv
// Bench for npu_bram_arbiter: directed scenarios plus random traffic, with a
// behavioural npu_bram_ctrl/BRAM stub and a transaction-level reference model.
module tb_npu_bram_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid, req_we, req_ready, rsp_valid;
    logic [N*32-1:0]  req_addr;
    logic [N*W-1:0]   req_wdata;
    logic [W-1:0]     rsp_data, ctrl_din;
    logic [W-1:0]     ctrl_dout = '0;
    logic             ctrl_rst, ctrl_rden, busy;
    logic [31:0]      ctrl_offset;

    npu_bram_arbiter #(.NUM_REQ(N), .RD_BITS(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ctrl_rst(ctrl_rst), .ctrl_rden(ctrl_rden), .ctrl_offset(ctrl_offset),
        .ctrl_din(ctrl_din), .ctrl_dout(ctrl_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Controller + BRAM stub: registered wren (writes whenever out of reset and not reading).
    logic [W-1:0] mem [0:255];
    logic         wren_r = 1'b0;
    logic [31:0]  waddr_r = '0;
    logic [W-1:0] wdin_r = '0;
    int           wr_count = 0;

    always @(posedge clk) begin
        if (wren_r) begin
            mem[waddr_r[7:0]] <= wdin_r;
            wr_count <= wr_count + 1;
        end
        wren_r  <= !ctrl_rst && !ctrl_rden;
        waddr_r <= ctrl_offset;
        wdin_r  <= ctrl_din;
        if (!ctrl_rst && ctrl_rden) ctrl_dout <= mem[ctrl_offset[7:0]];
    end

    typedef struct {
        int           req;
        logic         we;
        logic [31:0]  addr;
        logic [W-1:0] data;
    } op_t;

    op_t          opq[$];
    int           glog[$];
    logic [W-1:0] ref_mem[int];
    int           ready_at[N];
    int           max_gap = 0;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           free_at, ptr, op_a, rsp_at, rsp_who;
    logic         op_we_m;
    logic [31:0]  op_addr_m;
    logic [W-1:0] op_data_m, rsp_exp, last_rsp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int head(input int r);
        for (int i = 0; i < opq.size(); i++) if (opq[i].req == r) return i;
        return -1;
    endfunction

    task automatic add(input int r, input logic we, input logic [31:0] a, input logic [W-1:0] d);
        op_t o;
        o.req = r; o.we = we; o.addr = a; o.data = d;
        opq.push_back(o);
    endtask

    task automatic model_reset();
        free_at = cyc; ptr = 0; op_a = -100; rsp_at = -1; op_we_m = 1'b1;
        op_addr_m = '0; op_data_m = '0;
        for (int r = 0; r < N; r++) ready_at[r] = cyc;
    endtask

    // One cycle: drive requests, then compare outputs with the transaction model.
    task automatic step();
        logic [N-1:0] v, exp_ready, exp_rsp;
        int w;
        @(negedge clk);
        for (int r = 0; r < N; r++) begin
            int h;
            h = head(r);
            v[r] = (h >= 0) && (cyc >= ready_at[r]);
            req_valid[r] = v[r];
            if (h >= 0) begin
                req_we[r] = opq[h].we;
                req_addr[32*r +: 32] = opq[h].addr;
                req_wdata[W*r +: W] = opq[h].data;
            end else begin
                req_we[r] = 1'($urandom_range(0, 1));
                req_addr[32*r +: 32] = $urandom;
                req_wdata[W*r +: W] = $urandom;
            end
        end
        #1;
        w = -1;
        if (cyc >= free_at)
            for (int k = 0; k < N; k++) if (w < 0 && v[(ptr + k) % N]) w = (ptr + k) % N;
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        exp_rsp = '0;
        if (cyc == rsp_at) exp_rsp[rsp_who] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (cyc == rsp_at) begin
            check("rsp_data", 64'(rsp_data), 64'(rsp_exp));
            last_rsp = rsp_data;
        end
        check("ctrl_rst", 64'(ctrl_rst), 64'(!(cyc == op_a + 1 || (!op_we_m && cyc == op_a + 2))));
        check("ctrl_rden", 64'(ctrl_rden), 64'(!op_we_m && (cyc == op_a + 1 || cyc == op_a + 2)));
        check("busy", 64'(busy), 64'(cyc > op_a && cyc < free_at));
        if (cyc == op_a + 1 || cyc == op_a + 2) check("ctrl_offset", 64'(ctrl_offset), 64'(op_addr_m));
        if (op_we_m && cyc == op_a + 1) check("ctrl_din", 64'(ctrl_din), 64'(op_data_m));
        if (w >= 0) begin
            int h;
            h = head(w);
            glog.push_back(w);
            op_a = cyc; op_we_m = opq[h].we; op_addr_m = opq[h].addr; op_data_m = opq[h].data;
            if (opq[h].we) begin
                ref_mem[int'(opq[h].addr)] = opq[h].data;
                free_at = cyc + 3;
            end else begin
                rsp_at = cyc + 3; rsp_who = w;
                rsp_exp = ref_mem.exists(int'(opq[h].addr)) ? ref_mem[int'(opq[h].addr)] : '0;
                free_at = cyc + 4;
            end
            ptr = (w + 1) % N;
            ready_at[w] = cyc + 1 + int'($urandom_range(0, max_gap));
            opq.delete(h);
        end
        cyc++;
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while ((opq.size() > 0 || cyc < free_at || cyc <= rsp_at) && n < budget) begin
            step();
            n++;
        end
        check("run_budget", 64'(n < budget), 64'(1));
        repeat (2) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int exp4[6];
        for (int i = 0; i < 256; i++) mem[i] = '0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        model_reset();

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ctrl_rst", 64'(ctrl_rst), 64'(1));
        check("rst_ctrl_rden", 64'(ctrl_rden), 64'(0));
        check("rst_ctrl_offset", 64'(ctrl_offset), 64'(0));
        check("rst_ctrl_din", 64'(ctrl_din), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;

        // Idle for 100 cycles
        repeat (100) step();

        // req0 writes 0xDEADBEEF to 0x10
        wr0 = wr_count;
        add(0, 1'b1, 32'h10, 32'hDEADBEEF);
        run(20);
        check("t2_mem", 64'(mem[8'h10]), 64'(32'hDEADBEEF));
        check("t2_wr_count", 64'(wr_count - wr0), 64'(1));

        // req1 reads it back
        glog.delete();
        add(1, 1'b0, 32'h10, '0);
        run(20);
        check("t3_grants", 64'(glog.size()), 64'(1));
        if (glog.size() > 0) check("t3_grant", 64'(glog[0]), 64'(1));
        check("t3_rsp", 64'(last_rsp), 64'(32'hDEADBEEF));

        // Pointer now at 2: req3 must beat req0
        glog.delete();
        add(0, 1'b0, 32'h10, '0);
        add(3, 1'b1, 32'h30, 32'h3333_0003);
        run(30);
        check("t5_grants", 64'(glog.size()), 64'(2));
        if (glog.size() == 2) begin
            check("t5_first", 64'(glog[0]), 64'(3));
            check("t5_second", 64'(glog[1]), 64'(0));
        end

        // Bring the pointer back to 0, then all four requesters contend
        add(3, 1'b1, 32'h31, 32'h3131_3131);
        run(20);
        glog.delete();
        add(0, 1'b1, 32'h40, 32'hA0A0_0000);
        add(1, 1'b0, 32'h40, '0);
        add(2, 1'b1, 32'h42, 32'hA2A2_2222);
        add(3, 1'b0, 32'h30, '0);
        add(0, 1'b0, 32'h42, '0);
        add(1, 1'b1, 32'h41, 32'hA1A1_1111);
        run(60);
        exp4 = '{0, 1, 2, 3, 0, 1};
        check("t4_grants", 64'(glog.size()), 64'(6));
        for (int i = 0; i < 6 && i < glog.size(); i++) check("t4_order", 64'(glog[i]), 64'(exp4[i]));

        // Asynchronous reset in RD_WAIT of a req2 read
        glog.delete();
        add(2, 1'b0, 32'h10, '0);
        for (int i = 0; i < 10 && glog.size() == 0; i++) step();
        check("t6_granted", 64'(glog.size()), 64'(1));
        step();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_ctrl_rst", 64'(ctrl_rst), 64'(1));
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_rsp_valid", 64'(rsp_valid), 64'(0));
        check("t6_ctrl_offset", 64'(ctrl_offset), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        glog.delete();
        add(2, 1'b0, 32'h20, '0);
        add(1, 1'b0, 32'h24, '0);
        run(30);
        check("t6_grants", 64'(glog.size()), 64'(2));
        if (glog.size() == 2) begin
            check("t6_first", 64'(glog[0]), 64'(1));
            check("t6_second", 64'(glog[1]), 64'(2));
        end

        // Random traffic with idle gaps
        max_gap = 5;
        for (int i = 0; i < 40; i++)
            add(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 15)), $urandom);
        run(2000);
        for (int a = 0; a < 16; a++)
            if (ref_mem.exists(a)) check("rand_mem", 64'(mem[a]), 64'(ref_mem[a]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
